kernel_mac_pipe: RTL and testbench

Pipelined, parametrised fixed-point multiply stage for the convolver: multiplies a flattened KERNEL_SIZE×KERNEL_SIZE weight window by a pixel window lane-by-lane, then rounds and saturates each product back to DATA_WIDTH. It also produces the saturated window sum, so the downstream adder stage becomes optional. A valid/ready handshake with full backpressure sits between the window buffer and the accumulator/activation stage, and a sticky saturation counter is provided for debug.

---
 rtl/kernel_mac_pipe.sv | 166 ++++++++++++++++
 tb/tb_kernel_mac_pipe.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_mac_pipe.sv
// Three-stage fixed-point window multiplier for the convolver.
// Per-lane round/saturate, saturated window sum, sticky saturation counter.
module kernel_mac_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BIT    = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int ROUND       = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] pixel_data,
  input  logic in_valid,
  output logic in_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] sum,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0] lane_sat,
  output logic out_valid,
  input  logic out_ready,
  output logic [15:0] sat_count,
  input  logic sat_clear
);

  localparam int N  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DW;
  localparam int QW = PW + 1;
  localparam int SW = DW + $clog2(N);

  localparam logic signed [DW-1:0] MAXD =
    {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIND =
    {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [QW-1:0] QMAX =
    {{(QW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [QW-1:0] QMIN =
    {{(QW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [SW-1:0] SMAX =
    {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN =
    {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [QW-1:0] RND =
    (ROUND != 0) ? (QW'(1) << (FRAC_BIT-1)) : '0;

  logic en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // stage 1: full-width products
  logic signed [PW-1:0] prod_c  [N];
  logic signed [PW-1:0] s1_prod [N];
  logic                 s1_valid;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      prod_c[i] = $signed(weights[i*DW +: DW])
                * $signed(pixel_data[i*DW +: DW]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      for (int i = 0; i < N; i++) begin
        s1_prod[i] <= '0;
      end
    end else if (en) begin
      s1_valid <= in_valid;
      for (int i = 0; i < N; i++) begin
        s1_prod[i] <= prod_c[i];
      end
    end
  end

  // stage 2: round, shift, clamp
  logic signed [QW-1:0] ext_c  [N];
  logic signed [QW-1:0] q_c    [N];
  logic signed [DW-1:0] lane_c [N];
  logic [N-1:0]         sat_c;

  always_comb begin
    sat_c = '0;
    for (int i = 0; i < N; i++) begin
      ext_c[i]  = {s1_prod[i][PW-1], s1_prod[i]};
      q_c[i]    = (ext_c[i] + RND) >>> FRAC_BIT;
      lane_c[i] = q_c[i][DW-1:0];
      if (q_c[i] > QMAX) begin
        lane_c[i] = MAXD;
        sat_c[i]  = 1'b1;
      end else if (q_c[i] < QMIN) begin
        lane_c[i] = MIND;
        sat_c[i]  = 1'b1;
      end
    end
  end

  logic signed [DW-1:0] s2_lane [N];
  logic [N-1:0]         s2_sat;
  logic                 s2_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sat   <= '0;
      for (int i = 0; i < N; i++) begin
        s2_lane[i] <= '0;
      end
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sat   <= sat_c;
      for (int i = 0; i < N; i++) begin
        s2_lane[i] <= lane_c[i];
      end
    end
  end

  // stage 3: window sum with headroom, then clamp
  logic signed [SW-1:0] acc_c;
  logic signed [DW-1:0] sum_c;

  always_comb begin
    acc_c = '0;
    for (int i = 0; i < N; i++) begin
      acc_c = acc_c + SW'(s2_lane[i]);
    end
    sum_c = acc_c[DW-1:0];
    if (acc_c > SMAX) begin
      sum_c = MAXD;
    end else if (acc_c < SMIN) begin
      sum_c = MIND;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      sum       <= '0;
      lane_sat  <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      sum       <= sum_c;
      lane_sat  <= s2_sat;
      for (int i = 0; i < N; i++) begin
        result[i*DW +: DW] <= s2_lane[i];
      end
    end
  end

  logic out_xfer;

  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_count <= '0;
    end else if (out_xfer && (|lane_sat)
                 && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_kernel_mac_pipe.sv
// Scoreboard bench for kernel_mac_pipe: random and directed windows
// against an integer-arithmetic reference model.
module tb_kernel_mac_pipe;

  localparam int DW  = 16;
  localparam int FB  = 8;
  localparam int KS  = 5;
  localparam int RND = 1;
  localparam int N   = KS * KS;
  localparam int NW  = N * DW;
  localparam longint VMAX = (longint'(1) << (DW-1)) - 1;
  localparam longint VMIN = -(longint'(1) << (DW-1));

  typedef struct {
    logic [NW-1:0] res;
    logic [DW-1:0] sum;
    logic [N-1:0]  sat;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [NW-1:0] weights;
  logic [NW-1:0] pixel_data;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] result;
  logic [DW-1:0] sum;
  logic [N-1:0]  lane_sat;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   sat_count;
  logic          sat_clear;

  kernel_mac_pipe #(
    .DATA_WIDTH (DW),
    .FRAC_BIT   (FB),
    .KERNEL_SIZE(KS),
    .ROUND      (RND)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .weights   (weights),
    .pixel_data(pixel_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .sum       (sum),
    .lane_sat  (lane_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_count (sat_count),
    .sat_clear (sat_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];
  int   pops = 0;
  logic [NW-1:0] last_res;
  logic [DW-1:0] last_sum;
  logic [N-1:0]  last_sat;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  task automatic fail(input string nm);
    checks++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  // fixed-point product rounded by floor((p + half) / 2^FB), then clamped
  function automatic exp_t model(input logic [NW-1:0] w,
                                 input logic [NW-1:0] x);
    exp_t e;
    longint p, q, s, half;
    logic signed [DW-1:0] a, b;
    half  = RND ? (longint'(1) << (FB-1)) : 0;
    s     = 0;
    e.res = '0;
    e.sat = '0;
    for (int i = 0; i < N; i++) begin
      a = w[i*DW +: DW];
      b = x[i*DW +: DW];
      p = longint'(a) * longint'(b);
      q = (p + half) >>> FB;
      if (q > VMAX) begin
        q = VMAX;
        e.sat[i] = 1'b1;
      end else if (q < VMIN) begin
        q = VMIN;
        e.sat[i] = 1'b1;
      end
      e.res[i*DW +: DW] = q[DW-1:0];
      s += q;
    end
    if (s > VMAX) s = VMAX;
    else if (s < VMIN) s = VMIN;
    e.sum = s[DW-1:0];
    return e;
  endfunction

  function automatic logic [NW-1:0] fill(input logic [DW-1:0] v);
    return {N{v}};
  endfunction

  function automatic logic [NW-1:0] rand_win();
    logic [NW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0: r[i*DW +: DW] = DW'($urandom);
        1: r[i*DW +: DW] = DW'($urandom_range(0, 1023) - 512);
        2: case ($urandom_range(0, 3))
             0: r[i*DW +: DW] = 16'h7FFF;
             1: r[i*DW +: DW] = 16'h8000;
             2: r[i*DW +: DW] = 16'hFFFF;
             default: r[i*DW +: DW] = 16'h0001;
           endcase
        default: r[i*DW +: DW] = DW'($urandom_range(0, 255));
      endcase
    end
    return r;
  endfunction

  // input side of the scoreboard
  always @(negedge clk) begin
    if (!reset && in_valid && in_ready)
      exp_q.push_back(model(weights, pixel_data));
  end

  // output side: pop/compare, stall hold, sat_count tracking
  logic [15:0]   mcnt = '0;
  logic          stall_prev = 1'b0;
  logic [NW-1:0] h_res;
  logic [DW-1:0] h_sum;
  logic [N-1:0]  h_sat;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      mcnt       = '0;
      stall_prev = 1'b0;
    end else begin
      chk("sat_count", 64'(sat_count), 64'(mcnt));
      if (stall_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_sum", 64'(sum), 64'(h_sum));
        chk("hold_sat", 64'(lane_sat), 64'(h_sat));
        checks++;
        if (result === h_res) passes++;
        else $display("FAIL hold_result: got %h expected %h",
                      result, h_res);
      end
      if (out_valid && !out_ready)
        chk("in_ready_stall", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: got beat expected none");
        end else begin
          e = exp_q.pop_front();
          pops++;
          checks++;
          if (result === e.res) passes++;
          else $display("FAIL result: got %h expected %h",
                        result, e.res);
          chk("sum", 64'(sum), 64'(e.sum));
          chk("lane_sat", 64'(lane_sat), 64'(e.sat));
          last_res = result;
          last_sum = sum;
          last_sat = lane_sat;
          if (e.sat != 0 && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
        end
      end
      if (sat_clear) mcnt = '0;
      stall_prev = out_valid && !out_ready;
      h_res = result;
      h_sum = sum;
      h_sat = lane_sat;
    end
  end

  task automatic send(input logic [NW-1:0] w, input logic [NW-1:0] x);
    int t;
    t          = 0;
    weights    = w;
    pixel_data = x;
    in_valid   = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) fail("send");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) fail("drain");
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NW-1:0] w, x;
    logic          acc;
    int            lat, p0, cyc;
    logic [15:0]   sc0;

    reset      = 1'b1;
    in_valid   = 1'b0;
    weights    = '0;
    pixel_data = '0;
    out_ready  = 1'b1;
    sat_clear  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result[63:0]), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_lane_sat", 64'(lane_sat), 64'd0);
    chk("rst_sat_count", 64'(sat_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // basic: 1.5 * 2.0 in every lane
    send(fill(16'h0180), fill(16'h0200));
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd3);
    drain();
    chk("basic_lane0", 64'(last_res[15:0]), 64'h0300);
    chk("basic_lane24", 64'(last_res[NW-1 -: DW]), 64'h0300);
    chk("basic_sum", 64'(last_sum), 64'h4B00);
    chk("basic_sat", 64'(last_sat), 64'd0);

    // saturation in both directions
    sc0 = sat_count;
    w = '0;
    x = '0;
    w[15:0] = 16'h7FFF;  x[15:0] = 16'h7FFF;
    w[31:16] = 16'h8000; x[31:16] = 16'h7FFF;
    send(w, x);
    drain();
    chk("sat_lane0", 64'(last_res[15:0]), 64'h7FFF);
    chk("sat_lane1", 64'(last_res[31:16]), 64'h8000);
    chk("sat_flags", 64'(last_sat), 64'h3);
    chk("sat_sum", 64'(last_sum), 64'hFFFF);
    chk("sat_inc", 64'(sat_count), 64'(sc0 + 16'd1));

    // rounding at the half-LSB boundary
    w = '0;
    x = '0;
    w[15:0] = 16'h0001;  x[15:0] = 16'h0080;
    w[31:16] = 16'hFFFF; x[31:16] = 16'h0080;
    send(w, x);
    drain();
    chk("round_pos", 64'(last_res[15:0]), 64'h0001);
    chk("round_neg", 64'(last_res[31:16]), 64'h0000);

    // backpressure: out_ready low for cycles 4..7
    p0 = pops;
    fork
      begin
        for (int k = 0; k < 6; k++) send(rand_win(), rand_win());
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_beats", 64'(pops - p0), 64'd6);

    // random traffic with random backpressure
    acc = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 9) < 7);
      if (!(in_valid && !acc)) begin
        in_valid   = ($urandom_range(0, 9) < 7);
        weights    = rand_win();
        pixel_data = rand_win();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // reset with beats in flight
    for (int k = 0; k < 3; k++) send(rand_win(), rand_win());
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_cnt", 64'(sat_count), 64'd0);
    exp_q.delete();
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_stale", 64'(out_valid), 64'd0);

    // drive sat_count to its ceiling
    w = '0;
    w[15:0] = 16'h7FFF;
    weights    = w;
    pixel_data = w;
    in_valid   = 1'b1;
    cyc = 0;
    while (sat_count != 16'hFFFF && cyc < 70000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (sat_count != 16'hFFFF) fail("sat_fill");
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    chk("sat_stick", 64'(sat_count), 64'hFFFF);

    // clear wins over a simultaneous saturating transfer
    send(w, w);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("clr_align", 64'(out_valid), 64'd1);
    sat_clear = 1'b1;
    @(posedge clk);
    #1;
    sat_clear = 1'b0;
    chk("clr_prio", 64'(sat_count), 64'd0);
    drain();
    chk("leftover", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
